// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} words; flush overrides push/pop.
// Handshake: push/pop are single-cycle strobes sampled at clk; head is valid whenever count != 0.
module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_pop;
  logic              do_push;

  assign do_pop  = pop & (cnt != '0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push & ((cnt < CNT_W'(DEPTH)) | do_pop);
  assign count   = cnt;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      cnt  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: PC register, fetch queue and RUN/FAULT control.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
// Handshake: decode takes the head when if_valid & id_ready at clk; a redirect kills the head shown that cycle.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  output logic              fetch_fault
);

  localparam int CNT_W  = $clog2(FQ_DEPTH) + 1;
  localparam int DATA_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_target;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              fault;
  logic              redirect_take;
  logic              pop;
  logic              push;
  state_t            state;

`ifdef IFETCH_MISALIGN_TRAP_EN
  state_t state_next;
  logic   misaligned;

  assign misaligned = |redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // FAULT is terminal until reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (redirect_valid && misaligned) state_next = ST_FAULT;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_RUN;
    endcase
  end

  assign redirect_target = misaligned ? redirect_pc : {redirect_pc[ADDR_W-1:2], 2'b00};
  assign fetch_fault     = fault;
`else
  assign state           = ST_RUN;
  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign fetch_fault     = 1'b0;
`endif

  assign fault         = (state == ST_FAULT);
  // While faulted, imem_addr must keep showing the faulting PC, so redirects are ignored.
  assign redirect_take = redirect_valid & ~fault;
  assign if_valid      = (count != '0) & ~fault;
  assign pop           = if_valid & id_ready;
  assign push          = fetch_en & ~redirect_valid & ~fault &
                         ((count < CNT_W'(FQ_DEPTH)) | pop);
  assign imem_addr     = pc;
  assign if_pc         = head[DATA_W-1 -: ADDR_W];
  assign if_instr      = head[INSTR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pc <= RESET_PC;
    else if (redirect_take) pc <= redirect_target;
    else if (push)          pc <= pc + ADDR_W'(PC_STEP);
  end

  fetch_queue #(
    .DEPTH  (FQ_DEPTH),
    .DATA_W (DATA_W)
  ) u_fetch_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop & ~redirect_valid),
    .flush (redirect_take),
    .wdata ({pc, imem_instr}),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; word k of the instruction memory is 32'h1000_0000 + k.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;

  logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
  logic        if_valid, fetch_fault;
  logic [31:0] imem_addr_w, imem_instr_w, if_instr_w, if_pc_w;
  logic        if_valid_w, fetch_fault_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr   = 32'h1000_0000 + (imem_addr >> 2);
  assign imem_instr_w = 32'h1000_0000 + (imem_addr_w >> 2);

  ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .fetch_fault(fetch_fault)
  );

  ifetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr_w),
    .imem_instr(imem_instr_w), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid_w), .if_instr(if_instr_w), .if_pc(if_pc_w), .id_ready(id_ready),
    .fetch_fault(fetch_fault_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset pulse stays clear of any clock edge.
  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    checks++; if (imem_addr_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_addr_w: got %h want fffffffc", imem_addr_w); end
  endtask

  task automatic test_stream();
    step(); do_reset();
    fetch_en = 1'b1; id_ready = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL st_c0_addr: got %h want 0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL st_c0_valid: got %b want 0", if_valid); end
    step();
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL st_c1_valid: got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL st_c1_pc: got %h want 0", if_pc); end
    checks++; if (if_instr !== 32'h1000_0000) begin failures++; $display("FAIL st_c1_instr: got %h want 10000000", if_instr); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(k * 4)) begin failures++; $display("FAIL st_seq_pc k=%0d: got %b/%h want 1/%h", k, if_valid, if_pc, 32'(k * 4)); end
      checks++; if (if_instr !== 32'h1000_0000 + 32'(k)) begin failures++; $display("FAIL st_seq_instr k=%0d: got %h want %h", k, if_instr, 32'h1000_0000 + 32'(k)); end
    end
  endtask

  task automatic test_backpressure();
    step(); do_reset();
    fetch_en = 1'b1; id_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL bp_head c=%0d: got %b/%h want 1/0", c, if_valid, if_pc); end
      if (c >= 2) begin
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL bp_addr c=%0d: got %h want 8", c, imem_addr); end
      end
    end
    id_ready = 1'b1;
    #1;
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL bp_out0: got %h want 0", if_pc); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin failures++; $display("FAIL bp_out1: got %b/%h want 1/4", if_valid, if_pc); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin failures++; $display("FAIL bp_out2: got %b/%h want 1/8", if_valid, if_pc); end
    checks++; if (if_instr !== 32'h1000_0002) begin failures++; $display("FAIL bp_out2_instr: got %h want 10000002", if_instr); end
  endtask

  task automatic test_redirect_full();
    step(); do_reset();
    fetch_en = 1'b1; id_ready = 1'b0;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL rd_oldhead: got %b/%h want 1/0", if_valid, if_pc); end
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rd_flush_valid: got %b want 0", if_valid); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rd_addr: got %h want 100", imem_addr); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin failures++; $display("FAIL rd_first: got %b/%h want 1/100", if_valid, if_pc); end
    checks++; if (if_instr !== 32'h1000_0040) begin failures++; $display("FAIL rd_first_instr: got %h want 10000040", if_instr); end
    id_ready = 1'b1;
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin failures++; $display("FAIL rd_second: got %b/%h want 1/104", if_valid, if_pc); end
  endtask

  task automatic test_redirect_pop_misalign();
    step(); do_reset();
    fetch_en = 1'b1; id_ready = 1'b1;
    step(); step();
    checks++; if (if_pc !== 32'h4) begin failures++; $display("FAIL rp_pre: got %h want 4", if_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rp_flush: got %b want 0", if_valid); end
`ifdef IFETCH_MISALIGN_TRAP_EN
    checks++; if (imem_addr !== 32'h102) begin failures++; $display("FAIL rp_fault_addr: got %h want 102", imem_addr); end
    checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL rp_fault: got %b want 1", fetch_fault); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (if_valid !== 1'b0 || fetch_fault !== 1'b1) begin failures++; $display("FAIL rp_fault_hold c=%0d: got %b/%b want 0/1", c, if_valid, fetch_fault); end
      checks++; if (imem_addr !== 32'h102) begin failures++; $display("FAIL rp_fault_addr_hold c=%0d: got %h want 102", c, imem_addr); end
    end
    step(); do_reset();
    #1;
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rp_fault_clear: got %b want 0", fetch_fault); end
`else
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rp_align_addr: got %h want 100", imem_addr); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rp_nofault: got %b want 0", fetch_fault); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin failures++; $display("FAIL rp_first: got %b/%h want 1/100", if_valid, if_pc); end
    step();
    checks++; if (if_pc !== 32'h104) begin failures++; $display("FAIL rp_second: got %h want 104", if_pc); end
`endif
  endtask

  task automatic test_wrap();
    step(); do_reset();
    fetch_en = 1'b1; id_ready = 1'b1;
    #1;
    checks++; if (imem_addr_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_addr0: got %h want fffffffc", imem_addr_w); end
    step();
    checks++; if (if_valid_w !== 1'b1 || if_pc_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_pc0: got %b/%h want 1/fffffffc", if_valid_w, if_pc_w); end
    checks++; if (if_instr_w !== 32'h4FFF_FFFF) begin failures++; $display("FAIL wr_instr0: got %h want 4fffffff", if_instr_w); end
    checks++; if (imem_addr_w !== 32'h0) begin failures++; $display("FAIL wr_addr1: got %h want 0", imem_addr_w); end
    step();
    checks++; if (if_valid_w !== 1'b1 || if_pc_w !== 32'h0) begin failures++; $display("FAIL wr_pc1: got %b/%h want 1/0", if_valid_w, if_pc_w); end
    checks++; if (if_instr_w !== 32'h1000_0000) begin failures++; $display("FAIL wr_instr1: got %h want 10000000", if_instr_w); end
  endtask

  task automatic test_fetch_disable();
    step(); do_reset();
    fetch_en = 1'b1; id_ready = 1'b0;
    step(); step();
    fetch_en = 1'b0; id_ready = 1'b1;
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin failures++; $display("FAIL fd_drain1: got %b/%h want 1/4", if_valid, if_pc); end
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL fd_addr1: got %h want 8", imem_addr); end
    step();
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fd_empty: got %b want 0", if_valid); end
    step();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("FAIL fd_hold: got %b/%h want 0/8", if_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h200 || if_valid !== 1'b0) begin failures++; $display("FAIL fd_redirect: got %h/%b want 200/0", imem_addr, if_valid); end
  endtask

  task automatic test_async_reset();
    step(); do_reset();
    fetch_en = 1'b1; id_ready = 1'b1;
    step(); step();
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL ar_pre: got %b want 1", if_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL ar_drop: got %b/%h want 0/0", if_valid, imem_addr); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop_misalign();
    test_wrap();
    test_fetch_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
